// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmit frame sequencer.
package i2s_pkg;
  localparam int WIDTH_DEF  = 8;
  localparam int FRAME_BITS = 2 * WIDTH_DEF;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
endpackage

// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO; the caller only asserts push when not full and pop when not empty.
module i2s_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [W-1:0]            din_i,
  output logic [W-1:0]            dout_o,
  output logic [$clog2(DEPTH):0]  level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign level_o = cnt_q;
endmodule

// File: rtl/i2s_tx_controller.sv
// I2S transmit frame sequencer: buffers stereo samples, runs the bit counter and WS,
// and presents one frame word per frame to the serializer, inserting silence on underrun.
module i2s_tx_controller
  import i2s_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic                         SCK,
  input  logic                         reset,
  input  logic                         Enable,
  input  logic                         SampleValid,
  input  logic [2*WIDTH-1:0]           SampleData,
  output logic                         SampleReady,
  output logic [2*WIDTH-1:0]           LoadData,
  output logic [$clog2(2*WIDTH)-1:0]   BitIndex,
  output logic                         WS,
  output logic                         FrameStart,
  output logic                         Underrun,
  input  logic                         ClearUnderrun,
  output logic [$clog2(DEPTH):0]       Level,
  output logic                         Active
);
  localparam int FB = 2 * WIDTH;
  localparam int BW = $clog2(FB);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [BW-1:0] LAST  = BW'(FB - 1);
  localparam logic [BW-1:0] WS_LO = BW'(WIDTH - 1);
  localparam logic [BW-1:0] WS_HI = BW'(FB - 2);
  localparam logic [LW-1:0] FULL  = LW'(DEPTH);

  state_t        state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          ws_q, ws_d;
  logic [FB-1:0] load_q, load_d;
  logic          und_q, und_d;
  logic          push, pop, empty;
  logic [FB-1:0] fifo_dout;
  logic [LW-1:0] level;

  assign empty       = (level == '0);
  assign SampleReady = (level != FULL);
  assign push        = SampleValid && SampleReady;

  i2s_sample_fifo #(.W(FB), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (SCK),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (SampleData),
    .dout_o  (fifo_dout),
    .level_o (level)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    load_d  = load_q;
    und_d   = und_q;
    pop     = 1'b0;
    if (ClearUnderrun) und_d = 1'b0;
    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (Enable) state_d = PRIME;
      end
      PRIME: begin
        bit_d = '0;
        if (!Enable) state_d = IDLE;
        else if (!empty) begin
          pop     = 1'b1;
          load_d  = fifo_dout;
          state_d = RUN;
        end
      end
      RUN, DRAIN: begin
        bit_d = bit_q + 1'b1;
        // RUN, or DRAIN re-armed by Enable, loads the next word at the boundary.
        if (state_q == RUN || Enable) begin
          state_d = Enable ? RUN : DRAIN;
          if (bit_q == LAST) begin
            if (!empty) begin
              pop    = 1'b1;
              load_d = fifo_dout;
            end else begin
              load_d = '0;
              und_d  = 1'b1;
            end
          end
        end else if (bit_q == LAST) begin
          state_d = IDLE;
          bit_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    ws_d = (state_d == RUN || state_d == DRAIN) && (bit_d >= WS_LO) && (bit_d <= WS_HI);
  end

  always_ff @(posedge SCK) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      ws_q    <= 1'b0;
      load_q  <= '0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      ws_q    <= ws_d;
      load_q  <= load_d;
      und_q   <= und_d;
    end
  end

  assign LoadData   = load_q;
  assign BitIndex   = bit_q;
  assign WS         = ws_q;
  assign Underrun   = und_q;
  assign Level      = level;
  assign Active     = (state_q != IDLE);
  assign FrameStart = (bit_q == '0) && (state_q == RUN || state_q == DRAIN);
endmodule

// File: tb/tb_i2s_tx_controller.sv
// Directed bench: stimulus queues expected frame words; a negedge monitor
// reassembles each serial frame and compares it against the queue.
module tb_i2s_tx_controller;
  import i2s_pkg::*;

  logic        SCK = 1'b0;
  logic        reset, Enable, SampleValid, ClearUnderrun;
  logic [15:0] SampleData;
  logic        SampleReady, WS, FrameStart, Underrun, Active;
  logic [15:0] LoadData;
  logic [3:0]  BitIndex;
  logic [2:0]  Level;

  int vectors = 0;
  int errs    = 0;

  frame_t exp_q[$];
  bit     mon_en = 1'b0;
  bit     in_frame = 1'b0;
  frame_t cur_exp, sh;
  logic [15:0] wsp;
  int     nb;
  bit     seq_bad;

  frame_t s3 [3] = '{16'h8142, 16'h7E18, 16'hC0DE};
  frame_t fv [6] = '{16'hF00D, 16'hBEEF, 16'h1234, 16'h8001, 16'hDEAD, 16'hDEAD};
  frame_t s6 [3] = '{16'h3C3C, 16'h9669, 16'h0FF0};

  i2s_tx_controller #(.WIDTH(8), .DEPTH(4)) dut (
    .SCK(SCK), .reset(reset), .Enable(Enable), .SampleValid(SampleValid),
    .SampleData(SampleData), .SampleReady(SampleReady), .LoadData(LoadData),
    .BitIndex(BitIndex), .WS(WS), .FrameStart(FrameStart), .Underrun(Underrun),
    .ClearUnderrun(ClearUnderrun), .Level(Level), .Active(Active)
  );

  always #5 SCK = ~SCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_bit(input int b);
    for (int i = 0; i < 100; i++) begin
      @(negedge SCK);
      if (Active === 1'b1 && BitIndex == b[3:0] && (b != 0 || FrameStart === 1'b1)) return;
    end
    vectors++; errs++;
    $display("FAIL wait_bit: BitIndex=%0d Active=%b, required bit %0d within 100 SCKs", BitIndex, Active, b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge SCK);
      if (Active === 1'b0) return;
    end
    vectors++; errs++;
    $display("FAIL wait_idle: Active=%b BitIndex=%0d, required Active=0 within 100 SCKs", Active, BitIndex);
  endtask

  // Monitor: one frame = 16 consecutive bits starting at FrameStart.
  always @(negedge SCK) begin
    if (mon_en) begin
      if (Active !== 1'b1) in_frame = 1'b0;
      else begin
        if (FrameStart === 1'b1) begin
          if (in_frame) chk("frame_cut_bits", nb, 16);
          if (exp_q.size() == 0) begin
            vectors++; errs++;
            $display("FAIL unexpected_frame: LoadData=%h, required no frame", LoadData);
            cur_exp = 'x;
          end else cur_exp = exp_q.pop_front();
          in_frame = 1'b1; nb = 0; sh = '0; wsp = '0; seq_bad = 1'b0;
        end
        if (in_frame) begin
          if (BitIndex != nb[3:0]) seq_bad = 1'b1;
          sh = {sh[14:0], LoadData[15-BitIndex]};
          wsp[nb] = WS;
          nb++;
          if (nb == 16) begin
            chk("serial_word", sh, cur_exp);
            chk("ws_pattern", wsp, 16'h7F80);
            chk("bit_sequence_bad", seq_bad, 0);
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; Enable = 1'b0; SampleValid = 1'b0; SampleData = '0; ClearUnderrun = 1'b0;
    repeat (2) @(negedge SCK);
    chk("rst_level", Level, 0);       chk("rst_ready", SampleReady, 1);
    chk("rst_active", Active, 0);     chk("rst_load", LoadData, 0);
    chk("rst_underrun", Underrun, 0); chk("rst_ws", WS, 0);
    reset = 1'b0; mon_en = 1'b1;

    // Single frame, then disable mid-frame so it drains to IDLE.
    SampleData = 16'hA5C3; SampleValid = 1'b1; Enable = 1'b1; exp_q.push_back(16'hA5C3);
    @(negedge SCK); SampleValid = 1'b0;
    chk("t2_level_primed", Level, 1); chk("t2_active", Active, 1); chk("t2_fs_prime", FrameStart, 0);
    @(negedge SCK);
    chk("t2_fs", FrameStart, 1); chk("t2_load", LoadData, 16'hA5C3); chk("t2_level", Level, 0);
    wait_bit(3); Enable = 1'b0;
    wait_idle();
    chk("t2_load_hold", LoadData, 16'hA5C3); chk("t2_bit_idle", BitIndex, 0);
    chk("t2_ws_idle", WS, 0); chk("t2_underrun", Underrun, 0);

    // Stream of three back-to-back frames.
    for (int k = 0; k < 3; k++) begin
      SampleData = s3[k]; SampleValid = 1'b1; exp_q.push_back(s3[k]);
      @(negedge SCK);
    end
    SampleValid = 1'b0; chk("t3_level3", Level, 3); Enable = 1'b1;
    wait_bit(0); wait_bit(0); wait_bit(0);
    chk("t3_level_f3", Level, 0);
    wait_bit(2); Enable = 1'b0;
    wait_idle();
    chk("t3_underrun", Underrun, 0);

    // Underrun, with set-wins-over-clear at the boundary.
    SampleData = 16'h5A96; SampleValid = 1'b1; Enable = 1'b1;
    exp_q.push_back(16'h5A96); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    @(negedge SCK); SampleValid = 1'b0;
    wait_bit(0); wait_bit(1); chk("t4_und_f1", Underrun, 0);
    wait_bit(15); wait_bit(1);
    chk("t4_und_f2", Underrun, 1); chk("t4_load_f2", LoadData, 0);
    wait_bit(15); ClearUnderrun = 1'b1;
    @(negedge SCK); ClearUnderrun = 1'b0; chk("t4_set_wins", Underrun, 1);
    wait_bit(3); ClearUnderrun = 1'b1;
    @(negedge SCK); ClearUnderrun = 1'b0; chk("t4_cleared", Underrun, 0); Enable = 1'b0;
    wait_idle();
    chk("t4_no_drain_und", Underrun, 0);

    // Fill to full while idle, then a refused push at a popping boundary.
    for (int k = 0; k < 6; k++) begin
      SampleData = fv[k]; SampleValid = 1'b1;
      @(negedge SCK);
    end
    SampleValid = 1'b0;
    chk("t5_level_full", Level, 4); chk("t5_ready_full", SampleReady, 0);
    Enable = 1'b1; exp_q.push_back(16'hF00D); exp_q.push_back(16'hBEEF);
    wait_bit(2); SampleData = 16'h7777; SampleValid = 1'b1;
    @(negedge SCK);
    chk("t5_refill", Level, 4); chk("t5_ready0", SampleReady, 0); SampleData = 16'hCAFE;
    wait_bit(15); chk("t5_level_b15", Level, 4);
    @(negedge SCK); SampleValid = 1'b0;
    chk("t5_level_after", Level, 3); chk("t5_ready1", SampleReady, 1); chk("t5_fs", FrameStart, 1);

    // Reset mid-RUN with Level=3.
    wait_bit(8); chk("t1_ws_pre", WS, 1);
    reset = 1'b1; Enable = 1'b0;
    @(negedge SCK);
    chk("t1_level", Level, 0); chk("t1_ws", WS, 0); chk("t1_bit", BitIndex, 0);
    chk("t1_load", LoadData, 0); chk("t1_active", Active, 0); chk("t1_ready", SampleReady, 1);
    @(negedge SCK); reset = 1'b0;

    // Disable at bit 5, re-enable at bit 10, then a true drain to IDLE.
    for (int k = 0; k < 3; k++) begin
      SampleData = s6[k]; SampleValid = 1'b1; exp_q.push_back(s6[k]);
      @(negedge SCK);
    end
    SampleValid = 1'b0; Enable = 1'b1;
    wait_bit(0); wait_bit(5); Enable = 1'b0;
    wait_bit(10); Enable = 1'b1;
    wait_bit(1); chk("t6_pop_reenable", Level, 1);
    wait_bit(5); Enable = 1'b0;
    wait_idle();
    chk("t6_no_pop", Level, 1); chk("t6_bit_idle", BitIndex, 0);
    Enable = 1'b1;
    wait_bit(0); chk("t6_level_last", Level, 0);
    wait_bit(5); Enable = 1'b0;
    wait_idle();

    repeat (2) @(negedge SCK);
    chk("frames_pending", exp_q.size(), 0);
    chk("frame_open", in_frame, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
